// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Single-entry ALU issue stage with a valid/ready request side and a
//   valid/ready result side. ADD, SUB and the three shifts finish in one
//   cycle. MUL is an iterative shift-add that takes one multiplier bit per
//   cycle, LSB first. The result, flag and error are held in DONE until the
//   consumer takes them. A new request can be accepted on the same edge that
//   hands off the previous result.
//
//   Build option: define ALU_ISSUE_STAGE_MUL_EN to include the multiplier
//   and the MUL_RUN state. When it is undefined, op 101 is reported as an
//   illegal op and busy is tied low.
//
//   Parameters
//     WIDTH      operand width, at least 2
//   Ports
//     clk        clock; all state changes on its rising edge
//     rst_n      asynchronous active-low reset
//     in_valid   request present
//     in_ready   stage can take a request this cycle
//     op         000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 SAR, 101 MUL
//     in1, in2   operands; unsigned, except in1 is signed for SAR
//     out_valid  result is held and valid
//     out_ready  consumer takes the result
//     result     registered result, 2*WIDTH bits
//     flag       registered status bit for the op
//     error      registered illegal-op indicator
//     busy       high while a MUL is iterating
module alu_issue_stage #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag,
  output logic               error,
  output logic               busy
);

  if (WIDTH < 2) begin : g_width_check
    $error("alu_issue_stage: WIDTH must be at least 2");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_SAR = 3'b100;

  // A shift amount of WIDTH or more gets clamped to WIDTH, which shifts
  // every operand bit out.
  localparam logic [WIDTH-1:0] SHAMT_MAX = WIDTH'(WIDTH);

`ifdef ALU_ISSUE_STAGE_MUL_EN
  localparam logic [1:0]       MUL_RUN  = 2'd1;
  localparam logic [2:0]       OP_MUL   = 3'b101;
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`endif

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               flag_q, flag_d;
  logic               error_q, error_d;

  logic               accept;
  logic [WIDTH:0]     addSum;
  logic [WIDTH-1:0]   shiftAmt;
  logic [2*WIDTH-1:0] shlWide, shrWide, sarWide;
  logic [2*WIDTH-1:0] fastResult;
  logic               fastFlag, fastError;

  // In IDLE we can always take a request. In DONE we can take one only when
  // the held result leaves on the same edge.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  // The right shifts work on {in1, zeros}. The upper half holds the shifted
  // value, and the lower half collects the bits that fell off, so the flag
  // is the OR of the lower half.
  assign addSum   = {1'b0, in1} + {1'b0, in2};
  assign shiftAmt = (in2 >= SHAMT_MAX) ? SHAMT_MAX : in2;
  assign shlWide  = {{WIDTH{1'b0}}, in1} << shiftAmt;
  assign shrWide  = {in1, {WIDTH{1'b0}}} >> shiftAmt;
  assign sarWide  = $signed({in1, {WIDTH{1'b0}}}) >>> shiftAmt;

  // Single-cycle result for every op except MUL. Any op not listed is
  // illegal. Without the multiplier, that includes 101.
  always_comb begin
    fastResult = '0;
    fastFlag   = 1'b0;
    fastError  = 1'b0;
    case (op)
      OP_ADD: begin
        fastResult = {{(WIDTH-1){1'b0}}, addSum};
        fastFlag   = addSum[WIDTH];
      end
      OP_SUB: begin
        fastResult = {{WIDTH{1'b0}}, in1 - in2};
        fastFlag   = (in1 < in2);
      end
      OP_SHL: begin
        fastResult = shlWide;
        fastFlag   = |shlWide[2*WIDTH-1:WIDTH];
      end
      OP_SHR: begin
        fastResult = {{WIDTH{1'b0}}, shrWide[2*WIDTH-1:WIDTH]};
        fastFlag   = |shrWide[WIDTH-1:0];
      end
      OP_SAR: begin
        fastResult = {{WIDTH{1'b0}}, sarWide[2*WIDTH-1:WIDTH]};
        fastFlag   = |sarWide[WIDTH-1:0];
      end
      default: fastError = 1'b1;
    endcase
  end

`ifdef ALU_ISSUE_STAGE_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   mulCnt_q, mulCnt_d;
  logic [2*WIDTH-1:0] accSum;

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set.
  assign accSum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy   = (state_q == MUL_RUN);
`else
  assign busy   = 1'b0;
`endif

  // Next-state logic. A result handshake normally returns the stage to
  // IDLE. A same-edge accept overrides that so there is no bubble.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_d   = flag_q;
    error_d  = error_q;
`ifdef ALU_ISSUE_STAGE_MUL_EN
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mulCnt_d = mulCnt_q;

    if (state_q == MUL_RUN) begin
      acc_d    = accSum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      mulCnt_d = mulCnt_q + 1'b1;
      // The last step writes the output registers directly. This puts
      // out_valid WIDTH+1 cycles after the accept.
      if (mulCnt_q == CNT_LAST) begin
        state_d  = DONE;
        result_d = accSum;
        flag_d   = |accSum[2*WIDTH-1:WIDTH];
        error_d  = 1'b0;
      end
    end
`endif

    if ((state_q == DONE) && out_ready) begin
      state_d = IDLE;
    end

    if (accept) begin
`ifdef ALU_ISSUE_STAGE_MUL_EN
      if (op == OP_MUL) begin
        state_d  = MUL_RUN;
        mcand_d  = {{WIDTH{1'b0}}, in1};
        mplier_d = in2;
        acc_d    = '0;
        mulCnt_d = '0;
      end else
`endif
      begin
        state_d  = DONE;
        result_d = fastResult;
        flag_d   = fastFlag;
        error_d  = fastError;
      end
    end
  end

  // State and output registers. Reset clears everything at once, so a
  // partly finished operation is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flag_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef ALU_ISSUE_STAGE_MUL_EN
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mulCnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      error_q  <= error_d;
`ifdef ALU_ISSUE_STAGE_MUL_EN
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mulCnt_q <= mulCnt_d;
`endif
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flag      = flag_q;
  assign error     = error_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Self-checking bench for alu_issue_stage with WIDTH=4. When a request is
//   accepted, the bench pushes the expected {result, flag, error} onto a
//   queue. When the result is handed off, it pops that entry and compares.
//   Expected values come from an integer reference model. MUL expectations
//   follow ALU_ISSUE_STAGE_MUL_EN in the same way as the design.
module tb_alu_issue_stage;

  localparam int W = 4;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           flag;
    logic           err;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           flag;
  logic           error;
  logic           busy;

  int   testsRun;
  int   testsFailed;
  exp_t sb[$];

  // Directed vectors: {op, in1, in2}
  int vecTab [12][3] = '{
    '{1, 3, 5},  '{4, 8, 1},  '{2, 15, 6}, '{3, 11, 2},
    '{3, 5, 9},  '{4, 10, 7}, '{2, 3, 1},  '{0, 7, 8},
    '{6, 5, 5},  '{7, 15, 15}, '{1, 5, 5}, '{0, 15, 15}
  };

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag      (flag),
    .error     (error),
    .busy      (busy)
  );

  // 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Integer reference model of the ALU
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int ia, ib, n, r, sa;
    e  = '0;
    ia = int'(a);
    ib = int'(b);
    n  = (ib > W) ? W : ib;
    r  = 0;
    case (o)
      3'd0: begin r = ia + ib; e.flag = (r > 15); end
      3'd1: begin r = (ia - ib + 16) % 16; e.flag = (ia < ib); end
      3'd2: begin r = ia * (1 << n); e.flag = (r > 15); end
      3'd3: begin r = ia / (1 << n); e.flag = ((ia % (1 << n)) != 0); end
      3'd4: begin
        sa = (ia > 7) ? ia - 16 : ia;
        r  = (sa >>> n) & 15;
        e.flag = ((ia % (1 << n)) != 0);
      end
`ifdef ALU_ISSUE_STAGE_MUL_EN
      3'd5: begin r = ia * ib; e.flag = (r > 15); end
`endif
      default: e.err = 1'b1;
    endcase
    e.res = r[7:0];
    return e;
  endfunction

  // An empty queue gives all-X, which can never match real DUT outputs
  function automatic exp_t popExpected();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and wait for it to be accepted. The expected result
  // is queued just before the accepting edge. The operands are scrambled
  // afterwards so that late changes would show up.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    bit taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    op       = o;
    in1      = a;
    in2      = b;
    for (int i = 0; i < 20 && !taken; i++) begin
      #1;
      if (in_ready === 1'b1) begin
        sb.push_back(model(o, a, b));
        taken = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    testsRun++;
    if (!taken) begin
      testsFailed++;
      $display("[TB] FAIL accept_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
    end
    in_valid = 1'b0;
    op       = 3'($urandom);
    in1      = W'($urandom);
    in2      = W'($urandom);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    in1       = '0;
    in2       = '0;
    repeat (2) tick();
    testsRun++;
    if ({out_valid, flag, error, busy} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got vld/flag/err/busy=%b%b%b%b, required 0000",
               out_valid, flag, error, busy);
    end
    testsRun++;
    if (result !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_result: got %h, required 00", result);
    end
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    // The first edge after release must accept
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 3'd0;
    in1       = 4'd2;
    in2       = 4'd3;
    sb.push_back(model(3'd0, 4'd2, 4'd3));
    tick();
    in_valid = 1'b0;
    testsRun++;
    if (out_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL first_accept: out_valid=%b, required 1", out_valid);
    end
    e = popExpected();
    testsRun++;
    if ({result, flag, error} !== e) begin
      testsFailed++;
      $display("[TB] FAIL first_result: got %h/%b/%b, required %h/%b/%b",
               result, flag, error, e.res, e.flag, e.err);
    end
    tick();
  endtask

  task automatic test_add();
    exp_t e;
    out_ready = 1'b1;
    applyStimulus(3'd0, 4'd9, 4'd8);
    testsRun++;
    if (out_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL add_latency: out_valid=%b, required 1", out_valid);
    end
    e = popExpected();
    testsRun++;
    if ({result, flag, error} !== e) begin
      testsFailed++;
      $display("[TB] FAIL add_result: got %h/%b/%b, required %h/%b/%b",
               result, flag, error, e.res, e.flag, e.err);
    end
    testsRun++;
    if ({result, flag, error} !== {8'h11, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL add_vector: got %h/%b/%b, required 11/1/0", result, flag, error);
    end
    tick();
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL add_release: out_valid=%b, required 0", out_valid);
    end
  endtask

  // Directed vectors first, then random non-MUL ops issued back to back
  task automatic test_alu_ops();
    exp_t       e;
    logic [2:0] o;
    out_ready = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (i < 12) begin
        applyStimulus(3'(vecTab[i][0]), W'(vecTab[i][1]), W'(vecTab[i][2]));
      end else begin
        o = 3'($urandom_range(0, 7));
        if (o == 3'd5) o = 3'd4;
        applyStimulus(o, W'($urandom), W'($urandom));
      end
      e = popExpected();
      testsRun++;
      if (out_valid !== 1'b1 || {result, flag, error} !== e) begin
        testsFailed++;
        $display("[TB] FAIL alu_op[%0d]: got vld=%b %h/%b/%b, required vld=1 %h/%b/%b",
                 i, out_valid, result, flag, error, e.res, e.flag, e.err);
      end
    end
    tick();
  endtask

`ifdef ALU_ISSUE_STAGE_MUL_EN
  task automatic test_mul();
    exp_t e;
    int   mulA [4] = '{15, 0, 13, 1};
    int   mulB [4] = '{15, 9, 11, 1};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'd5, W'(mulA[k]), W'(mulB[k]));
      for (int c = 0; c < W; c++) begin
        testsRun++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
          testsFailed++;
          $display("[TB] FAIL mul_run[%0d] cycle %0d: busy/rdy/vld=%b%b%b, required 100",
                   k, c, busy, in_ready, out_valid);
        end
        tick();
      end
      e = popExpected();
      testsRun++;
      if ({out_valid, busy} !== 2'b10 || {result, flag, error} !== e) begin
        testsFailed++;
        $display("[TB] FAIL mul_done[%0d]: vld=%b busy=%b %h/%b/%b, required vld=1 busy=0 %h/%b/%b",
                 k, out_valid, busy, result, flag, error, e.res, e.flag, e.err);
      end
    end
    tick();
  endtask
`else
  task automatic test_mul_disabled();
    exp_t e;
    out_ready = 1'b1;
    applyStimulus(3'd5, 4'd3, 4'd3);
    e = popExpected();
    testsRun++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || {result, flag, error} !== e) begin
      testsFailed++;
      $display("[TB] FAIL mul_disabled: vld=%b busy=%b %h/%b/%b, required vld=1 busy=0 %h/%b/%b",
               out_valid, busy, result, flag, error, e.res, e.flag, e.err);
    end
    testsRun++;
    if ({result, flag, error} !== {8'h00, 1'b0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL mul_disabled_vec: got %h/%b/%b, required 00/0/1", result, flag, error);
    end
    tick();
    testsRun++;
    if ({out_valid, busy} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL mul_disabled_idle: vld=%b busy=%b, required 00", out_valid, busy);
    end
  endtask
`endif

  // The first ADD is held three cycles while out_ready is low. The second
  // ADD is accepted on the handoff edge and its result appears on the next
  // cycle.
  task automatic test_back_to_back();
    exp_t e1, e2;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 3'd0;
    in1       = 4'd5;
    in2       = 4'd6;
    sb.push_back(model(3'd0, 4'd5, 4'd6));
    tick();
    in1 = 4'd9;
    in2 = 4'd9;
    e1  = sb[0];
    for (int c = 0; c < 3; c++) begin
      testsRun++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {result, flag, error} !== e1) begin
        testsFailed++;
        $display("[TB] FAIL b2b_hold cycle %0d: vld=%b rdy=%b %h/%b/%b, required vld=1 rdy=0 %h/%b/%b",
                 c, out_valid, in_ready, result, flag, error, e1.res, e1.flag, e1.err);
      end
      tick();
    end
    out_ready = 1'b1;
    sb.push_back(model(3'd0, 4'd9, 4'd9));
    #1;
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_ready: in_ready=%b, required 1", in_ready);
    end
    e1 = popExpected();
    testsRun++;
    if ({result, flag, error} !== e1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first: got %h/%b/%b, required %h/%b/%b",
               result, flag, error, e1.res, e1.flag, e1.err);
    end
    tick();
    in_valid = 1'b0;
    e2 = popExpected();
    testsRun++;
    if (out_valid !== 1'b1 || {result, flag, error} !== e2) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second: vld=%b %h/%b/%b, required vld=1 %h/%b/%b",
               out_valid, result, flag, error, e2.res, e2.flag, e2.err);
    end
    tick();
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_idle: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    logic sawValid;
    // Reset while a result is held in DONE
    out_ready = 1'b0;
    applyStimulus(3'd0, 4'd12, 4'd7);
    testsRun++;
    if (out_valid !== 1'b1 || result !== 8'h13) begin
      testsFailed++;
      $display("[TB] FAIL hold_before_reset: vld=%b res=%h, required vld=1 res=13", out_valid, result);
    end
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({result, out_valid, flag, error, busy} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_done: res=%h vld/flag/err/busy=%b%b%b%b, required all 0",
               result, out_valid, flag, error, busy);
    end
    sb.delete();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    sawValid  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      sawValid = sawValid | out_valid;
    end
    testsRun++;
    if (sawValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ghost_after_done_reset: out_valid seen=%b, required 0", sawValid);
    end
`ifdef ALU_ISSUE_STAGE_MUL_EN
    // Reset two cycles into a MUL, with a nonzero result still held
    applyStimulus(3'd0, 4'd12, 4'd7);
    e = popExpected();
    testsRun++;
    if ({result, flag, error} !== e) begin
      testsFailed++;
      $display("[TB] FAIL pre_mul_add: got %h/%b/%b, required %h/%b/%b",
               result, flag, error, e.res, e.flag, e.err);
    end
    applyStimulus(3'd5, 4'd15, 4'd15);
    tick();
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL mul_busy_before_reset: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({result, out_valid, flag, error, busy} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_mul: res=%h vld/flag/err/busy=%b%b%b%b, required all 0",
               result, out_valid, flag, error, busy);
    end
    sb.delete();
    tick();
    tick();
    rst_n    = 1'b1;
    sawValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      sawValid = sawValid | out_valid | busy;
    end
    testsRun++;
    if (sawValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ghost_after_mul_reset: out_valid/busy seen=%b, required 0", sawValid);
    end
`else
    e = '0;
`endif
  endtask

  // Last-resort guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    op          = '0;
    in1         = '0;
    in2         = '0;
    test_reset();
    test_add();
    test_alu_ops();
`ifdef ALU_ISSUE_STAGE_MUL_EN
    test_mul();
`else
    test_mul_disabled();
`endif
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
